fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; opcode values are the ones decode matches on.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, insn} pairs between memory and decode.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, redirect flush.
// Optional FETCH_PERF_CNT_EN builds the delivered/dropped instruction counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = BASEADDR_DEFAULT,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [6:0]        opcode_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       drop_cnt_o
);

  localparam int                CW   = $clog2(QDEPTH) + 1;
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(4);

  fetch_state_t              state, state_next;
  logic [AWIDTH-1:0]         pc, pc_next;
  logic [AWIDTH-1:0]         rsp_pc, rsp_pc_next;
  logic [CW-1:0]             outstanding, outstanding_next;
  logic [CW-1:0]             stale, stale_next;
  logic [CW-1:0]             q_count;
  logic [CW:0]               in_use, credit_limit;
  logic                      pop, req_fire, live_rsp, q_empty, q_full;
  logic [AWIDTH+DWIDTH-1:0]  q_head;

  // A slot freed by this cycle's pop is reusable at once, giving 1 insn/cycle.
  assign pop          = insn_valid_o && insn_ready_i;
  assign in_use       = {1'b0, outstanding} + {1'b0, q_count};
  assign credit_limit = (CW+1)'(QDEPTH) + (CW+1)'(pop);

  assign imem_req_valid_o = (state == RUN) && (in_use < credit_limit);
  assign imem_addr_o      = pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign live_rsp         = imem_rsp_valid_i && (state == RUN) && !redirect_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= BASEADDR;
      rsp_pc      <= BASEADDR;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      rsp_pc      <= rsp_pc_next;
      outstanding <= outstanding_next;
      stale       <= stale_next;
    end
  end

  // Responses return in request order, so the oldest live request's PC is a running counter.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    rsp_pc_next      = rsp_pc;
    outstanding_next = outstanding + CW'(req_fire) - CW'(live_rsp);
    stale_next       = stale;

    if (req_fire)
      pc_next = pc + STEP;
    if (live_rsp)
      rsp_pc_next = rsp_pc + STEP;

    unique case (state)
      IDLE:  state_next = RUN;
      RUN:   state_next = RUN;
      FLUSH: begin
        if (imem_rsp_valid_i) begin
          stale_next = stale - CW'(1);
          if (stale == CW'(1))
            state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase

    // Everything still in flight, including a request accepted right now, becomes stale.
    if (redirect_i) begin
      pc_next          = redirect_pc_i;
      rsp_pc_next      = redirect_pc_i;
      outstanding_next = '0;
      stale_next       = stale + outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
      state_next       = (stale_next != '0) ? FLUSH : RUN;
    end
  end

  fetch_queue #(
    .WIDTH (AWIDTH + DWIDTH),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (live_rsp),
    .push_data ({rsp_pc, imem_rsp_data_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign insn_valid_o = !q_empty;
  assign insn_o       = q_empty ? DWIDTH'(NOP) : q_head[DWIDTH-1:0];
  assign pc_o         = q_empty ? BASEADDR : q_head[AWIDTH+DWIDTH-1:DWIDTH];
  assign opcode_o     = insn_o[6:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, drop_cnt;
  logic        drop_rsp;

  assign drop_rsp = imem_rsp_valid_i && !live_rsp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (pop)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (drop_rsp)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign drop_cnt_o  = drop_cnt;
`else
  assign fetch_cnt_o = 32'd0;
  assign drop_cnt_o  = 32'd0;
`endif

  // The credit rule guarantees a live response always finds room.
  rsp_has_room: assert property (@(posedge clk) disable iff (reset) !(live_rsp && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int          QDEPTH = 2;
  localparam logic [31:0] BASE   = 32'h0100_0000;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, reset;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        insn_valid_o, insn_ready_i;
  logic [31:0] insn_o, pc_o;
  logic [6:0]  opcode_o;
  logic [31:0] fetch_cnt_o, drop_cnt_o;

  fetch_unit #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE), .QDEPTH(QDEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .insn_valid_o     (insn_valid_o),
    .insn_ready_i     (insn_ready_i),
    .insn_o           (insn_o),
    .pc_o             (pc_o),
    .opcode_o         (opcode_o),
    .fetch_cnt_o      (fetch_cnt_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory environment knobs
  int lat = 1;
  int stall_pct = 0;
  bit rnd_data = 1'b0;
  int mem_q[$];

  // reference model
  typedef enum {M_IDLE, M_RUN, M_FLUSH} mode_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] insn;} entry_t;
  mode_t       m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_tags[$];
  entry_t      m_q[$];
  int          m_stale, m_fetch, m_drop;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_req_valid();
    int pending;
    pending = m_tags.size() + m_q.size();
    if (m_q.size() > 0 && insn_ready_i) pending--;
    return (m_mode == M_RUN) && (pending < QDEPTH);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = BASE; m_tags.delete(); m_q.delete();
    m_stale = 0; m_fetch = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit hs, pop, rsp;
    hs  = exp_req_valid() && imem_req_ready_i;
    pop = (m_q.size() > 0) && insn_ready_i;
    rsp = imem_rsp_valid_i;
    if (pop) begin void'(m_q.pop_front()); m_fetch++; end
    if (redirect_i) begin
      if (rsp) m_drop++;
      m_stale = m_stale + m_tags.size() + int'(hs) - int'(rsp);
      m_tags.delete(); m_q.delete();
      m_pc = redirect_pc_i;
      m_mode = (m_stale > 0) ? M_FLUSH : M_RUN;
    end else begin
      if (hs) begin m_tags.push_back(m_pc); m_pc = m_pc + 32'd4; end
      if (rsp) begin
        if (m_mode == M_FLUSH) begin
          m_stale--; m_drop++;
          if (m_stale == 0) m_mode = M_RUN;
        end else begin
          m_q.push_back({m_tags.pop_front(), imem_rsp_data_i});
        end
      end
      if (m_mode == M_IDLE) m_mode = M_RUN;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) model_reset();
    else model_step();
  end

  // memory: remember each accepted request and when its answer is due
  always @(negedge clk) begin
    if (!reset && imem_req_valid_o && imem_req_ready_i) mem_q.push_back(cyc + lat);
  end

  // compare process
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("req_valid", 32'(imem_req_valid_o), 32'(exp_req_valid()));
      checkOutput("req_addr", imem_addr_o, m_pc);
      checkOutput("insn_valid", 32'(insn_valid_o), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        checkOutput("pc_o", pc_o, m_q[0].pc);
        checkOutput("insn_o", insn_o, m_q[0].insn);
        checkOutput("opcode_o", 32'(opcode_o), 32'(m_q[0].insn[6:0]));
      end
      checkOutput("fetch_cnt", fetch_cnt_o, PERF ? 32'(m_fetch) : 32'd0);
      checkOutput("drop_cnt", drop_cnt_o, PERF ? 32'(m_drop) : 32'd0);
    end
  end

  task automatic applyStimulus(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
    @(posedge clk); #1;
    if (imem_rsp_valid_i) void'(mem_q.pop_front());
    imem_rsp_valid_i = 1'b0;
    if (mem_q.size() > 0)
      if (mem_q[0] <= cyc && $urandom_range(99) >= stall_pct) imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = rnd_data ? $urandom : 32'h0000_0013;
    imem_req_ready_i = rdy;
    insn_ready_i     = irdy;
    redirect_i       = redir;
    redirect_pc_i    = tgt;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
    checkOutput({tag, "_addr"}, imem_addr_o, BASE);
    checkOutput({tag, "_insn_valid"}, 32'(insn_valid_o), 32'd0);
    checkOutput({tag, "_insn"}, insn_o, 32'h0000_0013);
    checkOutput({tag, "_pc"}, pc_o, BASE);
    checkOutput({tag, "_opcode"}, 32'(opcode_o), 32'h13);
    checkOutput({tag, "_fetch_cnt"}, fetch_cnt_o, 32'd0);
    checkOutput({tag, "_drop_cnt"}, drop_cnt_o, 32'd0);
  endtask

  task automatic assert_reset();
    reset = 1'b1; imem_rsp_valid_i = 1'b0; redirect_i = 1'b0; mem_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; imem_req_ready_i = 1'b1; insn_ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_first_delivery(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1, 1, 0, 0);
      if (insn_valid_o) found = 1'b1;
    end
    checkOutput({name, "_seen"}, 32'(found), 32'd1);
    if (found) checkOutput({name, "_pc"}, pc_o, exp_pc);
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1; imem_req_ready_i = 1'b1; insn_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; redirect_i = 1'b0; redirect_pc_i = '0;
    #1 check_reset_values("reset");

    // streaming with a 1-cycle memory returning NOPs
    do_reset();
    checkOutput("idle_req", 32'(imem_req_valid_o), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c1_req", 32'(imem_req_valid_o), 32'd1);
    checkOutput("c1_addr", imem_addr_o, 32'h0100_0000);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c2_addr", imem_addr_o, 32'h0100_0004);
    checkOutput("c2_insn_valid", 32'(insn_valid_o), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c3_insn_valid", 32'(insn_valid_o), 32'd1);
    checkOutput("c3_pc", pc_o, 32'h0100_0000);
    checkOutput("c3_insn", insn_o, 32'h0000_0013);
    checkOutput("c3_req", 32'(imem_req_valid_o), 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("c4_pc", pc_o, 32'h0100_0004);
    repeat (10) applyStimulus(1, 1, 0, 0);

    // decode stalled: only QDEPTH requests may go out
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, 0);
      if (imem_req_valid_o && imem_req_ready_i) n++;
    end
    checkOutput("stall_req_count", 32'(n), 32'(QDEPTH));
    applyStimulus(1, 1, 0, 0);
    checkOutput("stall_release_req", 32'(imem_req_valid_o), 32'd1);
    checkOutput("stall_release_addr", imem_addr_o, 32'h0100_0008);
    checkOutput("stall_release_pc", pc_o, 32'h0100_0000);

    // latency 3, redirect with two requests in flight
    lat = 3;
    do_reset();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'h0100_0100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1, 1, 0, 0);
      if (imem_req_valid_o) found = 1'b1;
      else checkOutput("flush_no_insn", 32'(insn_valid_o), 32'd0);
    end
    checkOutput("flush_resume", 32'(found), 32'd1);
    checkOutput("flush_target", imem_addr_o, 32'h0100_0100);
    checkOutput("flush_drops", drop_cnt_o, PERF ? 32'd2 : 32'd0);
    wait_first_delivery("flush_first", 32'h0100_0100);

    // redirect coinciding with a response, a request accept and a pop
    lat = 1;
    do_reset();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'h0200_0040);
    applyStimulus(1, 1, 0, 0);
    checkOutput("same_cycle_empty", 32'(insn_valid_o), 32'd0);
    checkOutput("same_cycle_noreq", 32'(imem_req_valid_o), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("same_cycle_addr", imem_addr_o, 32'h0200_0040);
    checkOutput("same_cycle_drops", drop_cnt_o, PERF ? 32'd2 : 32'd0);
    checkOutput("same_cycle_fetch", fetch_cnt_o, PERF ? 32'd1 : 32'd0);
    wait_first_delivery("same_cycle_first", 32'h0200_0040);

    // PC wrap at the top of the address space
    rnd_data = 1'b1;
    do_reset();
    repeat (4) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1, 1, 0, 0);
      if (imem_req_valid_o && imem_addr_o == 32'hFFFF_FFFC) found = 1'b1;
    end
    checkOutput("wrap_seen", 32'(found), 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("wrap_addr", imem_addr_o, 32'h0000_0000);

    // reset while flushing
    lat = 3;
    do_reset();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'h0300_0000);
    applyStimulus(1, 1, 0, 0);
    @(posedge clk); #1;
    assert_reset();
    #1 check_reset_values("midflush");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lat = 1;
    @(negedge clk);
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_reset_addr", imem_addr_o, BASE);
    wait_first_delivery("post_reset_first", BASE);

    // randomized traffic
    stall_pct = 20;
    for (int blk = 0; blk < 12; blk++) begin
      lat = $urandom_range(4, 1);
      for (int i = 0; i < 50; i++) begin
        logic [31:0] tgt;
        tgt = $urandom;
        if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
        applyStimulus($urandom_range(99) < 80, $urandom_range(99) < 70,
                      $urandom_range(99) < 4, tgt);
      end
    end
    stall_pct = 0;
    repeat (10) applyStimulus(1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
